// File: rtl/vga_pkg.sv
// Shared video/text definitions: character codes, typewriter state encoding
// and the default last character position of a text page.
package vga_pkg;

  localparam logic [6:0] SPACE = 7'h20;

  localparam logic [7:0] TXT_LAST_XY = 8'h7F;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TYPING    = 2'd1,
    WAIT_NEXT = 2'd2,
    DONE      = 2'd3
  } txt_state_t;

endpackage

// File: rtl/game_txt_reveal_mask.sv
// Reveal mask: delays char_xy to line up with the page ROM output, compares it
// against the reveal limit and registers either the ROM code or SPACE.
module game_txt_reveal_mask
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_xy,
  input  logic [6:0] rom_char_code,
  input  logic [8:0] limit,
  output logic [6:0] char_code
);

  logic [7:0] xy_p0;
  logic       revealed;

  // Stage 0: match the one-cycle latency of the page ROM
  always_ff @(posedge clk) begin
    xy_p0 <= char_xy;
  end

  assign revealed = ({1'b0, xy_p0} < limit);

  // Stage 1: masked output register
  always_ff @(posedge clk) begin
    if (rst) begin
      char_code <= 7'd0;
    end else begin
      char_code <= revealed ? rom_char_code : SPACE;
    end
  end

endmodule

// File: rtl/game_txt_typewriter.sv
// Text-box typewriter: walks the page ROMs and reveals one position per
// TICKS_PER_CHAR frames. Define GAME_TXT_SKIP_EN to let next_req finish a page early.
module game_txt_typewriter
  import vga_pkg::*;
#(
  parameter int         PAGES          = 4,
  parameter int         TICKS_PER_CHAR = 2,
  parameter logic [7:0] LAST_XY        = TXT_LAST_XY
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       next_req,
  input  logic       frame_tick,
  input  logic [7:0] char_xy,
  input  logic [6:0] rom_char_code,
  output logic [((PAGES > 1) ? $clog2(PAGES) : 1)-1:0] page_sel,
  output logic [6:0] char_code,
  output logic       typing,
  output logic       page_done,
  output logic       all_done
);

  localparam int         PW         = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam logic [8:0] REVEAL_TOP = {1'b0, LAST_XY} + 9'd1;
  localparam logic [7:0] TICK_LAST  = 8'(TICKS_PER_CHAR - 1);
  localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);

  txt_state_t    state, state_nxt;
  logic [8:0]    reveal_cnt, reveal_nxt;
  logic [7:0]    tick_cnt, tick_nxt;
  logic [PW-1:0] page_nxt;
  logic [8:0]    mask_limit;
  logic          skip_hit;

  function automatic logic [8:0] sat_inc(input logic [8:0] v);
    return (v >= REVEAL_TOP) ? REVEAL_TOP : v + 9'd1;
  endfunction

`ifdef GAME_TXT_SKIP_EN
  assign skip_hit = next_req;
`else
  assign skip_hit = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    reveal_nxt = reveal_cnt;
    tick_nxt   = tick_cnt;
    page_nxt   = page_sel;
    if (start) begin
      state_nxt  = TYPING;
      reveal_nxt = 9'd0;
      tick_nxt   = 8'd0;
      page_nxt   = '0;
    end else begin
      case (state)
        TYPING: begin
          if (skip_hit) begin
            reveal_nxt = REVEAL_TOP;
            state_nxt  = WAIT_NEXT;
          end else if (reveal_cnt >= REVEAL_TOP) begin
            state_nxt = WAIT_NEXT;
          end else if (frame_tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_nxt   = 8'd0;
              reveal_nxt = sat_inc(reveal_cnt);
              // Leave TYPING on the same edge the last position is revealed
              if (sat_inc(reveal_cnt) == REVEAL_TOP) state_nxt = WAIT_NEXT;
            end else begin
              tick_nxt = tick_cnt + 8'd1;
            end
          end
        end
        WAIT_NEXT: begin
          if (next_req) begin
            if (page_sel == PAGE_LAST) begin
              state_nxt = DONE;
            end else begin
              state_nxt  = TYPING;
              page_nxt   = page_sel + 1'b1;
              reveal_nxt = 9'd0;
              tick_nxt   = 8'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Stage 0: state, counters and flags registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      reveal_cnt <= 9'd0;
      tick_cnt   <= 8'd0;
      page_sel   <= '0;
      typing     <= 1'b0;
      page_done  <= 1'b0;
      all_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      reveal_cnt <= reveal_nxt;
      tick_cnt   <= tick_nxt;
      page_sel   <= page_nxt;
      typing     <= (state_nxt == TYPING);
      page_done  <= (state_nxt == WAIT_NEXT);
      all_done   <= (state_nxt == DONE);
    end
  end

  // IDLE and DONE blank the whole box; WAIT_NEXT already holds REVEAL_TOP
  assign mask_limit = ((state == TYPING) || (state == WAIT_NEXT)) ? reveal_cnt : 9'd0;

  game_txt_reveal_mask u_mask (
    .clk           (clk),
    .rst           (rst),
    .char_xy       (char_xy),
    .rom_char_code (rom_char_code),
    .limit         (mask_limit),
    .char_code     (char_code)
  );

endmodule

// File: tb/tb_game_txt_typewriter.sv
// Directed bench for game_txt_typewriter with a two-page ROM model.
module tb_game_txt_typewriter;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       next_req = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] char_xy = 8'h00;
  logic [6:0] rom_char_code;
  logic [0:0] page_sel;
  logic [6:0] char_code;
  logic       typing, page_done, all_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] xy;
    logic       rev;
  } vec_t;

  vec_t tv_typ[6];
  vec_t tv_wait[4];

  game_txt_typewriter #(
    .PAGES(2), .TICKS_PER_CHAR(2), .LAST_XY(8'h7F)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .next_req(next_req),
    .frame_tick(frame_tick), .char_xy(char_xy), .rom_char_code(rom_char_code),
    .page_sel(page_sel), .char_code(char_code), .typing(typing),
    .page_done(page_done), .all_done(all_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] rom_fn(input logic pg, input logic [7:0] xy);
    return {1'b1, pg, xy[4:0]};
  endfunction

  always_ff @(posedge clk) rom_char_code <= rom_fn(page_sel, char_xy);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_xy(input string nm, input logic [7:0] xy, input logic rev, input logic pg);
    @(negedge clk) char_xy = xy;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk(nm, 32'(char_code), 32'(rev ? rom_fn(pg, xy) : SPACE));
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_next();
    @(negedge clk) next_req = 1'b1;
    @(negedge clk) next_req = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
    end
  endtask

  task automatic finish_page(input string nm);
    for (int i = 0; i < 400 && !page_done; i++) tick_n(1);
    chk(nm, 32'(page_done), 32'd1);
  endtask

  initial begin
    tv_typ[0] = '{"typ_xy00", 8'h00, 1'b1};
    tv_typ[1] = '{"typ_xy01", 8'h01, 1'b1};
    tv_typ[2] = '{"typ_xy02", 8'h02, 1'b0};
    tv_typ[3] = '{"typ_xy10", 8'h10, 1'b0};
    tv_typ[4] = '{"typ_xy7f", 8'h7F, 1'b0};
    tv_typ[5] = '{"typ_xyff", 8'hFF, 1'b0};
    tv_wait[0] = '{"wait_xy00", 8'h00, 1'b1};
    tv_wait[1] = '{"wait_xy7f", 8'h7F, 1'b1};
    tv_wait[2] = '{"wait_xy80", 8'h80, 1'b0};
    tv_wait[3] = '{"wait_xyff", 8'hFF, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_page_sel", 32'(page_sel), 32'd0);
    chk("rst_char_code", 32'(char_code), 32'd0);
    chk("rst_typing", 32'(typing), 32'd0);
    chk("rst_page_done", 32'(page_done), 32'd0);
    chk("rst_all_done", 32'(all_done), 32'd0);
    rst = 1'b0;
    chk_xy("idle_xy00", 8'h00, 1'b0, 1'b0);
    pulse_next();
    chk("idle_next_ignored", 32'(typing), 32'd0);

    // Start and partial reveal
    pulse_start();
    chk("start_typing", 32'(typing), 32'd1);
    chk("start_page", 32'(page_sel), 32'd0);
    tick_n(4);
    chk("reveal_after_4", 32'(dut.reveal_cnt), 32'd2);
    for (int i = 0; i < 6; i++) chk_xy(tv_typ[i].name, tv_typ[i].xy, tv_typ[i].rev, 1'b0);

    // next_req during TYPING at reveal_cnt = 5
    tick_n(6);
    chk("reveal_after_10", 32'(dut.reveal_cnt), 32'd5);
    pulse_next();
`ifdef GAME_TXT_SKIP_EN
    chk("skip_page_done", 32'(page_done), 32'd1);
    chk("skip_typing", 32'(typing), 32'd0);
    chk_xy("skip_xy7f", 8'h7F, 1'b1, 1'b0);
`else
    chk("noskip_typing", 32'(typing), 32'd1);
    chk("noskip_reveal", 32'(dut.reveal_cnt), 32'd5);
    tick_n(244);
    chk("reveal_127", 32'(dut.reveal_cnt), 32'd127);
    tick_n(1);
    chk("typing_before_last", 32'(typing), 32'd1);
    tick_n(1);
    chk("full_page_done", 32'(page_done), 32'd1);
    chk("full_typing_low", 32'(typing), 32'd0);
`endif

    // WAIT_NEXT masking and frame_tick immunity
    for (int i = 0; i < 4; i++) chk_xy(tv_wait[i].name, tv_wait[i].xy, tv_wait[i].rev, 1'b0);
    tick_n(3);
    chk("wait_tick_ignored", 32'(dut.reveal_cnt), 32'd128);
    chk("wait_still_done", 32'(page_done), 32'd1);

    // Advance to page 1
    pulse_next();
    chk("next_page_sel", 32'(page_sel), 32'd1);
    chk("next_reveal_clr", 32'(dut.reveal_cnt), 32'd0);
    chk("next_typing", 32'(typing), 32'd1);
    chk_xy("p1_xy00_space", 8'h00, 1'b0, 1'b1);
    finish_page("p1_full");

    // start and next_req together on the last page
    @(negedge clk) begin start = 1'b1; next_req = 1'b1; end
    @(negedge clk) begin start = 1'b0; next_req = 1'b0; end
    chk("start_wins_page", 32'(page_sel), 32'd0);
    chk("start_wins_typing", 32'(typing), 32'd1);
    chk("start_wins_all_done", 32'(all_done), 32'd0);

    // Walk to DONE
    finish_page("p0_full_b");
    pulse_next();
    finish_page("p1_full_b");
    pulse_next();
    chk("done_all_done", 32'(all_done), 32'd1);
    chk("done_typing", 32'(typing), 32'd0);
    chk("done_page_done", 32'(page_done), 32'd0);
    chk_xy("done_xy00", 8'h00, 1'b0, 1'b1);
    chk_xy("done_xy7f", 8'h7F, 1'b0, 1'b1);
    pulse_start();
    chk("restart_page", 32'(page_sel), 32'd0);
    chk("restart_typing", 32'(typing), 32'd1);
    chk("restart_all_done", 32'(all_done), 32'd0);

    // Reset in the middle of page 1
    finish_page("p0_full_c");
    pulse_next();
    tick_n(4);
    chk("pre_rst_page", 32'(page_sel), 32'd1);
    chk_xy("p1_xy01_rev", 8'h01, 1'b1, 1'b1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    chk("mid_rst_page", 32'(page_sel), 32'd0);
    chk("mid_rst_char", 32'(char_code), 32'd0);
    chk("mid_rst_typing", 32'(typing), 32'd0);
    chk("mid_rst_page_done", 32'(page_done), 32'd0);
    chk("mid_rst_all_done", 32'(all_done), 32'd0);
    chk("mid_rst_reveal", 32'(dut.reveal_cnt), 32'd0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
